// File: rtl/vpu_rf_pkg.sv
// Shared definitions for the vector register-file operand path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vpu_rf_pkg;

    localparam int DEF_WIDTH      = 64;
    localparam int DEF_ADDR_WIDTH = 5;

    // Operand fetch sequence: two back-to-back bank reads, then hold the bundle.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_A  = 3'd1,
        S_RD_B  = 3'd2,
        S_CAP_B = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

endpackage

// File: rtl/operand_slot.sv
// One operand register: captures bank read data, overridden by writeback forwarding.
// Latency: updates on the clock edge after capture/forward enable.
// Backpressure: none; value holds whenever no enable is active.
module operand_slot #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_cap_en,
    input  logic [WIDTH-1:0] i_cap_data,
    input  logic             i_fwd_en,
    input  logic [WIDTH-1:0] i_fwd_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_data;
    // Once forwarded, later bank data for this operand is stale (read sampled
    // before the write landed), so the capture must be suppressed.
    logic             r_fwd;

    // Forward beats capture; the sticky flag is cleared when a new request is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_fwd  <= 1'b0;
        end else if (i_clr) begin
            r_fwd  <= 1'b0;
        end else if (i_fwd_en) begin
            r_data <= i_fwd_data;
            r_fwd  <= 1'b1;
        end else if (i_cap_en && !r_fwd) begin
            r_data <= i_cap_data;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/operand_fetch_ctrl.sv
// Fetches two source operands from a 1-read-port bank and presents them to execute.
// Latency: op_valid 4 cycles after request accept; one request per 5 cycles.
// Backpressure: holds the bundle while op_ready=0; req_ready only asserted in IDLE.
module operand_fetch_ctrl
    import vpu_rf_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_src_a,
    input  logic [ADDR_WIDTH-1:0] req_src_b,
    input  logic [ADDR_WIDTH-1:0] req_dst,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_en,
    input  logic [WIDTH-1:0]      rd_data,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  wr_en,
    output logic [WIDTH-1:0]      wr_data,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [WIDTH-1:0]      wb_data,
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic [WIDTH-1:0]      op_a,
    output logic [WIDTH-1:0]      op_b,
    output logic [ADDR_WIDTH-1:0] op_dst
);

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_src_a;
    logic [ADDR_WIDTH-1:0] r_src_b;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic                  w_accept;
    logic                  w_fwd_a;
    logic                  w_fwd_b;
    logic                  w_cap_a;
    logic                  w_cap_b;

    assign w_accept = req_valid && req_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: fixed read sequence, then wait for execute to take the bundle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_next = S_RD_A;
            S_RD_A:  w_next = S_RD_B;
            S_RD_B:  w_next = S_CAP_B;
            S_CAP_B: w_next = S_HOLD;
            S_HOLD:  if (op_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs: all handshake/read controls forced low while reset is asserted.
    always_comb begin
        req_ready = 1'b0;
        op_valid  = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        if (!rst) begin
            case (r_state)
                S_IDLE: req_ready = 1'b1;
                S_RD_A: begin
                    rd_en   = 1'b1;
                    rd_addr = r_src_a;
                end
                S_RD_B: begin
                    rd_en   = 1'b1;
                    rd_addr = r_src_b;
                end
                S_HOLD:  op_valid = 1'b1;
                default: ;
            endcase
        end
    end

    // Latch the request addresses on accept; they stay fixed until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_src_a <= '0;
            r_src_b <= '0;
            r_dst   <= '0;
        end else if (w_accept) begin
            r_src_a <= req_src_a;
            r_src_b <= req_src_b;
            r_dst   <= req_dst;
        end
    end

    // Writebacks bypass straight to the bank write port.
    assign wr_en   = wb_valid;
    assign wr_addr = wb_addr;
    assign wr_data = wb_data;

    // Forward windows start at the cycle each operand's read is issued, since a
    // same-edge write is invisible to that read.
    assign w_fwd_a = wb_valid && (wb_addr == r_src_a) && (r_state != S_IDLE);
    assign w_fwd_b = wb_valid && (wb_addr == r_src_b) &&
                     ((r_state == S_RD_B) || (r_state == S_CAP_B) || (r_state == S_HOLD));
    assign w_cap_a = (r_state == S_RD_B);
    assign w_cap_b = (r_state == S_CAP_B);

    operand_slot #(.WIDTH(WIDTH)) u_slot_a (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_accept),
        .i_cap_en   (w_cap_a),
        .i_cap_data (rd_data),
        .i_fwd_en   (w_fwd_a),
        .i_fwd_data (wb_data),
        .o_data     (op_a)
    );

    operand_slot #(.WIDTH(WIDTH)) u_slot_b (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_accept),
        .i_cap_en   (w_cap_b),
        .i_cap_data (rd_data),
        .i_fwd_en   (w_fwd_b),
        .i_fwd_data (wb_data),
        .o_data     (op_b)
    );

    assign op_dst = r_dst;

endmodule

// File: doc/operand_fetch_ctrl.md
OPERAND_FETCH_CTRL -- requirements
Module: operand_fetch_ctrl

Interface
REQ-001 SHALL take parameter WIDTH, default 64, meaning operand/data bit width.
REQ-002 SHALL take parameter ADDR_WIDTH, default 5, meaning register address width (32 registers).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, meaning the instruction request is valid.
REQ-006 SHALL have port req_ready, output, 1, meaning a request is accepted this cycle.
REQ-007 SHALL have ports req_src_a, req_src_b and req_dst, input, ADDR_WIDTH each, meaning source and destination register addresses.
REQ-008 SHALL have ports rd_addr (output, ADDR_WIDTH), rd_en (output, 1) and rd_data (input, WIDTH), meaning the bank read port; the bank returns rd_data one cycle after rd_en/rd_addr are sampled.
REQ-009 SHALL have ports wr_addr (output, ADDR_WIDTH), wr_en (output, 1) and wr_data (output, WIDTH), meaning the bank write port.
REQ-010 SHALL have ports wb_valid (input, 1), wb_addr (input, ADDR_WIDTH) and wb_data (input, WIDTH), meaning the result writeback; it is always accepted.
REQ-011 SHALL have ports op_valid (output, 1), op_ready (input, 1), op_a and op_b (output, WIDTH each) and op_dst (output, ADDR_WIDTH), meaning the operand bundle sent to execute.

Function
REQ-012 SHALL implement states IDLE, RD_A, RD_B, CAP_B and HOLD.
REQ-013 SHALL drive req_ready=1 only in IDLE; req_valid&&req_ready latches src_a, src_b and dst and moves the FSM to RD_A.
REQ-014 SHALL, in RD_A, drive rd_en=1 and rd_addr=src_a, then go to RD_B.
REQ-015 SHALL, in RD_B, drive rd_en=1 and rd_addr=src_b, capture rd_data into op_a at the end of the cycle, then go to CAP_B.
REQ-016 SHALL, in CAP_B, drive rd_en=0, capture rd_data into op_b at the end of the cycle, then go to HOLD.
REQ-017 SHALL drive rd_en=0 and rd_addr=0 in IDLE, CAP_B and HOLD.
REQ-018 SHALL, in HOLD, drive op_valid=1 with op_a, op_b and op_dst stable; op_valid&&op_ready returns the FSM to IDLE.
REQ-019 SHALL give a latency from accept to op_valid of 4 cycles and a throughput of one request per 5 cycles when op_ready=1.
REQ-020 SHALL drive wr_en=wb_valid, wr_addr=wb_addr and wr_data=wb_data combinationally in every state, including during reset.
REQ-021 SHALL forward writebacks into operand A: the bank returns pre-write data on a same-edge read/write collision, so any wb_valid with wb_addr==src_a from RD_A through the HOLD handshake cycle overwrites op_a with wb_data, taking priority over rd_data capture.
REQ-022 SHALL apply the same forwarding rule to operand B for cycles RD_B through the HOLD handshake.
REQ-023 SHALL update both operands when src_a==src_b and a writeback matches.
REQ-024 SHALL keep op_dst equal to the latched req_dst and never forward into it.
REQ-025 SHALL ignore req_valid in any state other than IDLE.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, enter IDLE and clear op_a, op_b, op_dst and the latched addresses to 0.
REQ-027 SHALL drive op_valid=0, rd_en=0, rd_addr=0 and req_ready=0 while rst=1.
REQ-028 SHALL, on reset mid-operation, abandon the in-flight request without producing op_valid; req_ready=1 on the first cycle after rst falls.

Structure
REQ-029 SHALL place WIDTH/ADDR_WIDTH defaults and the FSM state enum in shared package vpu_rf_pkg.
REQ-030 SHALL implement each operand register with capture-enable and forward-override in a sub-module operand_slot, instantiated twice.

Verification
REQ-031 SHALL check basic fetch: preload r10=0xAAAAAAAAAAAAAAAA and r11=0xBBBBBBBBBBBBBBBB, then request src_a=10, src_b=11, dst=3 -> rd_addr 10 then 11 on consecutive cycles, op_valid 4 cycles after accept, with op_a and op_b matching and op_dst=3.
REQ-032 SHALL check same-edge forwarding: in RD_A, set wb_valid with wb_addr=10 and wb_data=0x1111111111111111 -> op_a=0x1111111111111111.
REQ-033 SHALL check late forwarding: in HOLD with op_ready=0, write wb_addr=11 with wb_data=0x2222222222222222 -> op_b updates the next cycle; then assert op_ready -> bundle accepted and req_ready=1.
REQ-034 SHALL check backpressure: hold op_ready=0 for 10 cycles -> op_valid stays 1, outputs stable, and req_ready stays 0 even with req_valid asserted.
REQ-035 SHALL check reset mid-operation: assert rst in RD_B -> next cycle all outputs are 0, op_valid never rises, and a fresh request completes normally.
REQ-036 SHALL check aliasing: request src_a=src_b=4 holding 0xA5A5A5A5A5A5A5A5, with a writeback of 0x5A5A5A5A5A5A5A5A to r4 in CAP_B -> op_a=op_b=0x5A5A5A5A5A5A5A5A.
